elbeth_mem_arbiter: RTL and testbench
=====================================

// Module: elbeth_mem_arbiter
// PURPOSE
//  Shares one unified memory port between the IF instruction requester (read-only) and the EXS data
//  requester (read/write). Produces the if_imem_ready/exs_dmem_ready handshakes that drive pipeline
//  stalls in the control unit. Sits between the core and the memory/bus adapter. Fixed priority:
//  data over instruction, because a pending data access freezes the whole pipeline.
// PARAMETERS
//  ADDR_WIDTH      32    address width, all ports
//  DATA_WIDTH      32    data width, all ports
//  TIMEOUT_CYCLES  255   cycles a granted access may wait for mem_ready (used only with ELBETH_MEM_TIMEOUT_EN)
// PORTS
//  clk          in   1           core clock
//  rst          in   1           synchronous, active-high reset
//  imem_en      in   1           instruction request; held high until imem_ready
//  imem_addr    in   ADDR_WIDTH  instruction address
//  imem_data    out  DATA_WIDTH  instruction read data; valid when imem_ready
//  imem_ready   out  1           1-cycle completion pulse
//  imem_error   out  1           access aborted by timeout; valid with imem_ready
//  dmem_en      in   1           data request; held high until dmem_ready
//  dmem_addr    in   ADDR_WIDTH  data address
//  dmem_wdata   in   DATA_WIDTH  store data
//  dmem_rw      in   4           0000 read; 0001 byte, 0011 half, 1111 word write enables
//  dmem_data    out  DATA_WIDTH  load data; valid when dmem_ready
//  dmem_ready   out  1           1-cycle completion pulse
//  dmem_error   out  1           access aborted by timeout; valid with dmem_ready
//  mem_en       out  1           memory request, held high until mem_ready
//  mem_addr     out  ADDR_WIDTH  registered address
//  mem_wdata    out  DATA_WIDTH  registered store data
//  mem_rw       out  4           registered write enables (0000 for instruction fetch)
//  mem_data     in   DATA_WIDTH  memory read data
//  mem_ready    in   1           memory completion, one cycle
// BEHAVIOUR
//  - FSM states: IDLE, SERVE_D, SERVE_I. Reset (rst=1 at clk edge) -> IDLE. Also on reset:
//    mem_en=0, mem_addr=0, mem_wdata=0, mem_rw=0, all *_ready=0, *_error=0.
//  - IDLE: if dmem_en, latch dmem_addr/wdata/rw into mem_* and go to SERVE_D. Else if imem_en,
//    latch imem_addr and mem_rw=0000 and go to SERVE_I. Else stay. Simultaneous requests: data wins.
//  - SERVE_x: mem_en=1, mem_* stable. On mem_ready: x_ready=mem_ready & x_en, passed through
//    combinationally in the same cycle. x_data=mem_data. Next state is IDLE.
//  - Minimum latency: request seen at edge N; mem_en high in cycle N+1; if mem_ready is high in
//    N+1, x_ready is high in N+1. There is one IDLE bubble between back-to-back accesses.
//  - Abandoned request (x_en drops while in SERVE_x, e.g. an IF flush on branch/exception): the
//    memory access still completes and the response is discarded. No x_ready is issued.
//  - The requester must deassert en, or present its next request, in the cycle after ready. An en
//    still high in IDLE is treated as a new request.
//  - The requester is never stalled by a change of its own inputs during SERVE. Inputs are sampled
//    only in IDLE.
//  - mem_ready while IDLE is ignored.
//  - Reset mid-access: the FSM returns to IDLE and mem_en drops on the next cycle. A late mem_ready
//    arriving afterwards is ignored.
// CONFIGURATION
//  ELBETH_MEM_TIMEOUT_EN defined:
//    - A cycle counter, width $clog2(TIMEOUT_CYCLES+1), clears when the FSM enters SERVE_x and
//      increments each cycle without mem_ready.
//    - When the counter reaches TIMEOUT_CYCLES with no mem_ready: x_ready=1 and x_error=1 for one
//      cycle, x_data=0, mem_en drops, next state IDLE.
//    - mem_ready arriving on the timeout cycle takes precedence: a normal completion, no error.
//  ELBETH_MEM_TIMEOUT_EN undefined: no counter; the access waits indefinitely; imem_error and
//    dmem_error are tied to 0.
// STRUCTURE
//  - elbeth_definitions.v: state encodings (ARB_IDLE/ARB_SERVE_D/ARB_SERVE_I) and MEM_RW_* codes.
//  - Sub-module elbeth_mem_watchdog (counter plus terminal-count flag) is instantiated only under
//    ELBETH_MEM_TIMEOUT_EN.
// TESTING
//  1. imem_en=1, addr=0x100; mem_ready 2 cycles after mem_en -> mem_rw=0000, mem_addr=0x100;
//     imem_ready pulses once with imem_data=mem_data.
//  2. imem_en and dmem_en rise together (dmem_rw=1111, addr=0x200, wdata=0xDEADBEEF) -> dmem
//     served first with mem_wdata=0xDEADBEEF; imem served after one IDLE bubble.
//  3. imem_en drops during SERVE_I, then mem_ready arrives -> no imem_ready; FSM IDLE next cycle.
//  4. rst=1 during SERVE_D -> next cycle all outputs 0, FSM IDLE; a late mem_ready produces no
//     dmem_ready.
//  5. With ELBETH_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready never asserted -> dmem_ready=1 and
//     dmem_error=1 in the 5th SERVE cycle; mem_en low next cycle. Without the macro: mem_en stays
//     high and no ready is issued.
//  6. mem_ready pulses while IDLE -> no *_ready asserted; state unchanged.

Source files
------------

// File: rtl/elbeth_mem_arbiter_pkg.sv
// Shared constants for the elbeth unified memory arbiter: FSM state codes and
// memory write-enable codes. Imported by the arbiter, its watchdog and benches.
package elbeth_mem_arbiter_pkg;

    // Arbiter FSM state encodings
    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_SERVE_D = 2'd1;
    localparam logic [1:0] ARB_SERVE_I = 2'd2;

    // Byte-lane write enables presented on mem_rw
    localparam logic [3:0] MEM_RW_READ = 4'b0000;
    localparam logic [3:0] MEM_RW_BYTE = 4'b0001;
    localparam logic [3:0] MEM_RW_HALF = 4'b0011;
    localparam logic [3:0] MEM_RW_WORD = 4'b1111;

endpackage

// File: rtl/elbeth_mem_arbiter_if.sv
// Bundle of the instruction port, data port and unified memory port around the
// arbiter. The slave modport is the arbiter's view (it serves the core and
// drives the memory); the master modport is the surrounding core + memory.
interface elbeth_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    // Instruction requester (read-only)
    logic                  imem_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  imem_ready;
    logic                  imem_error;

    // Data requester (read/write)
    logic                  dmem_en;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [3:0]            dmem_rw;
    logic [DATA_WIDTH-1:0] dmem_data;
    logic                  dmem_ready;
    logic                  dmem_error;

    // Unified memory port
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_rw;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_ready;

    modport slave (
        input  imem_en, imem_addr,
        output imem_data, imem_ready, imem_error,
        input  dmem_en, dmem_addr, dmem_wdata, dmem_rw,
        output dmem_data, dmem_ready, dmem_error,
        output mem_en, mem_addr, mem_wdata, mem_rw,
        input  mem_data, mem_ready
    );

    modport master (
        output imem_en, imem_addr,
        input  imem_data, imem_ready, imem_error,
        output dmem_en, dmem_addr, dmem_wdata, dmem_rw,
        input  dmem_data, dmem_ready, dmem_error,
        input  mem_en, mem_addr, mem_wdata, mem_rw,
        output mem_data, mem_ready
    );

endinterface

// File: rtl/elbeth_mem_watchdog.sv
// Access watchdog for the memory arbiter: counts cycles spent waiting for
// mem_ready and flags the terminal count. Only instantiated when
// ELBETH_MEM_TIMEOUT_EN is defined.
module elbeth_mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    // Wait-cycle counter; held at terminal count until cleared
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_tick && !o_expired_c) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired_c = (r_count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: shares one memory port between the instruction fetch
// and the data (load/store) requesters. Data has fixed priority because a
// pending data access freezes the whole pipeline. Requests are sampled only
// in IDLE; completions pass mem_ready straight through to the owner.
// Optional feature macro: ELBETH_MEM_TIMEOUT_EN (abort accesses that wait
// TIMEOUT_CYCLES without mem_ready, flagging *_error).
module elbeth_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                 clk,
    input logic                 rst,
    elbeth_mem_arbiter_if.slave bus
);

    import elbeth_mem_arbiter_pkg::*;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  w_load_d;
    logic                  w_load_i;
    logic                  w_serve_d;
    logic                  w_serve_i;
    logic                  w_serving;
    logic                  w_timeout;
    logic                  w_done;

    logic                  r_mem_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mem_rw;

    assign w_serve_d = (r_state == ARB_SERVE_D);
    assign w_serve_i = (r_state == ARB_SERVE_I);
    assign w_serving = w_serve_d | w_serve_i;
    assign w_done    = bus.mem_ready | w_timeout;

`ifdef ELBETH_MEM_TIMEOUT_EN
    logic w_expired_c;

    elbeth_mem_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (~w_serving),
        .i_tick      (w_serving & ~bus.mem_ready),
        .o_expired_c (w_expired_c)
    );

    // A mem_ready on the terminal cycle wins over the abort
    assign w_timeout      = w_serving & w_expired_c & ~bus.mem_ready;
    assign bus.imem_data  = w_timeout ? '0 : bus.mem_data;
    assign bus.dmem_data  = w_timeout ? '0 : bus.mem_data;
`else
    logic w_unused_cfg;

    assign w_unused_cfg   = ^32'(TIMEOUT_CYCLES);
    assign w_timeout      = 1'b0;
    assign bus.imem_data  = bus.mem_data;
    assign bus.dmem_data  = bus.mem_data;
`endif

    // Completion goes only to a requester still asking; abandoned accesses are dropped
    assign bus.dmem_ready = w_serve_d & bus.dmem_en & w_done;
    assign bus.imem_ready = w_serve_i & bus.imem_en & w_done;
    assign bus.dmem_error = w_serve_d & bus.dmem_en & w_timeout;
    assign bus.imem_error = w_serve_i & bus.imem_en & w_timeout;

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_rw    = r_mem_rw;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decode: data over instruction
    always_comb begin
        w_next_state = r_state;
        w_load_d     = 1'b0;
        w_load_i     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (bus.dmem_en) begin
                    w_next_state = ARB_SERVE_D;
                    w_load_d     = 1'b1;
                end else if (bus.imem_en) begin
                    w_next_state = ARB_SERVE_I;
                    w_load_i     = 1'b1;
                end
            end
            ARB_SERVE_D, ARB_SERVE_I: begin
                if (w_done) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // Capture the granted request and hold it stable for the whole access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rw    <= MEM_RW_READ;
        end else if (w_load_d) begin
            r_mem_en    <= 1'b1;
            r_mem_addr  <= bus.dmem_addr;
            r_mem_wdata <= bus.dmem_wdata;
            r_mem_rw    <= bus.dmem_rw;
        end else if (w_load_i) begin
            r_mem_en    <= 1'b1;
            r_mem_addr  <= bus.imem_addr;
            r_mem_wdata <= '0;
            r_mem_rw    <= MEM_RW_READ;
        end else if (w_serving && w_done) begin
            r_mem_en    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Bench for elbeth_mem_arbiter: directed scenarios plus randomized traffic
// from both requesters, checked by a scoreboard against a simple memory model.
module tb_elbeth_mem_arbiter;

    import elbeth_mem_arbiter_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    elbeth_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    elbeth_mem_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rw;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   total = 0;
    int   bad   = 0;

    int   lat_cfg     = 0;
    bit   resp_en     = 1'b1;
    int   inject_req  = 0;
    int   inject_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by reads: a fixed scramble of the address
    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Memory model: answers each access lat_cfg cycles after mem_en rises
    initial begin : responder
        int cnt;
        bit in_acc;
        cnt = 0;
        in_acc = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            bus.mem_data  = $urandom;
            if (inject_req != inject_done) begin
                bus.mem_ready = 1'b1;
                inject_done++;
            end else if (bus.mem_en && resp_en) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    cnt = (lat_cfg < 0) ? int'($urandom_range(3, 0)) : lat_cfg;
                end
                if (cnt == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_data  = hash(bus.mem_addr);
                    in_acc = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (!bus.mem_en) begin
                in_acc = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every ready must match the oldest outstanding request
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.imem_ready) begin
                if (iq.size() == 0) begin
                    chk("imem_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = iq.pop_front();
                    chk("imem_data", bus.imem_data, e.data);
                    chk("imem_error", 32'(bus.imem_error), 32'(e.err));
                    chk("imem_mem_addr", bus.mem_addr, e.addr);
                    chk("imem_mem_rw", 32'(bus.mem_rw), 32'(e.rw));
                    chk("imem_mem_en", 32'(bus.mem_en), 32'd1);
                end
            end
            if (bus.dmem_ready) begin
                if (dq.size() == 0) begin
                    chk("dmem_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = dq.pop_front();
                    chk("dmem_data", bus.dmem_data, e.data);
                    chk("dmem_error", 32'(bus.dmem_error), 32'(e.err));
                    chk("dmem_mem_addr", bus.mem_addr, e.addr);
                    chk("dmem_mem_wdata", bus.mem_wdata, e.wdata);
                    chk("dmem_mem_rw", 32'(bus.mem_rw), 32'(e.rw));
                    chk("dmem_mem_en", 32'(bus.mem_en), 32'd1);
                end
            end
        end
    end

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: got running expected finished at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    // One request from a port; optionally abandoned once its access is on the bus
    task automatic do_req(input bit is_d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] rw, input int abandon_after,
                          output int n_neg, output bit abandoned);
        exp_t e;
        bit   done;
        bit   rdy;
        bit   seen;
        e.addr  = a;
        e.wdata = wd;
        e.rw    = is_d ? rw : MEM_RW_READ;
        e.data  = hash(a);
        e.err   = 1'b0;
        if (is_d) dq.push_back(e);
        else      iq.push_back(e);
        @(posedge clk);
        #1;
        if (is_d) begin
            bus.dmem_en = 1'b1; bus.dmem_addr = a; bus.dmem_wdata = wd; bus.dmem_rw = rw;
        end else begin
            bus.imem_en = 1'b1; bus.imem_addr = a;
        end
        n_neg = 0;
        done = 1'b0;
        abandoned = 1'b0;
        while (!done) begin
            @(negedge clk);
            n_neg++;
            rdy = is_d ? bus.dmem_ready : bus.imem_ready;
            if (rdy) begin
                done = 1'b1;
            end else if (abandon_after >= 0 && n_neg > abandon_after && bus.mem_en &&
                         bus.mem_addr == a && !bus.mem_ready) begin
                if (is_d) void'(dq.pop_back());
                else      void'(iq.pop_back());
                abandoned = 1'b1;
                done = 1'b1;
            end else if (n_neg > 300) begin
                chk(is_d ? "dmem_req_wait" : "imem_req_wait", 32'd0, 32'd1);
                if (is_d) void'(dq.pop_back());
                else      void'(iq.pop_back());
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (is_d) bus.dmem_en = 1'b0;
        else      bus.imem_en = 1'b0;
        if (abandoned) begin
            seen = 1'b0;
            for (int k = 0; k < 50 && !seen; k++) begin
                @(negedge clk);
                if (bus.mem_ready) begin
                    seen = 1'b1;
                    chk("abandon_no_ready", 32'(is_d ? bus.dmem_ready : bus.imem_ready), 32'd0);
                end
            end
            if (!seen) chk("abandon_completion", 32'd0, 32'd1);
            @(negedge clk);
            chk("abandon_mem_en_low", 32'(bus.mem_en), 32'd0);
        end
    endtask

    task automatic rand_port(input bit is_d);
        logic [3:0]  rw_tab [4];
        logic [31:0] r;
        logic [31:0] a;
        int          ab_after;
        int          n;
        bit          ab;
        rw_tab = '{MEM_RW_READ, MEM_RW_BYTE, MEM_RW_HALF, MEM_RW_WORD};
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(3, 0)) @(posedge clk);
            r = $urandom;
            a = {is_d, r[30:2], 2'b00};
            ab_after = ($urandom_range(7, 0) == 0) ? int'($urandom_range(2, 0)) : -1;
            do_req(is_d, a, $urandom, rw_tab[$urandom_range(3, 0)], ab_after, n, ab);
        end
    endtask

    initial begin : main
        int n1;
        int n2;
        int cnt;
        bit ab1;
        bit ab2;
        exp_t e;
        rst = 1'b1;
        bus.imem_en = 1'b0; bus.imem_addr = '0;
        bus.dmem_en = 1'b0; bus.dmem_addr = '0; bus.dmem_wdata = '0; bus.dmem_rw = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
        chk("rst_readies", 32'({bus.imem_ready, bus.dmem_ready}), 32'd0);
        chk("rst_errors", 32'({bus.imem_error, bus.dmem_error}), 32'd0);

        // Single fetch, memory answers two cycles after mem_en
        lat_cfg = 2;
        do_req(1'b0, 32'h100, 32'h0, MEM_RW_READ, -1, n1, ab1);
        chk("t1_latency", n1, 32'd4);
        @(negedge clk);
        chk("t1_single_pulse", 32'(bus.imem_ready), 32'd0);

        // Simultaneous requests: data first, fetch after one idle bubble
        lat_cfg = 1;
        fork
            do_req(1'b1, 32'h200, 32'hDEADBEEF, MEM_RW_WORD, -1, n1, ab1);
            do_req(1'b0, 32'h104, 32'h0, MEM_RW_READ, -1, n2, ab2);
        join
        chk("t2_data_latency", n1, 32'd3);
        chk("t2_fetch_latency", n2, 32'd6);

        // Fetch abandoned mid-access
        lat_cfg = 3;
        do_req(1'b0, 32'h300, 32'h0, MEM_RW_READ, 1, n1, ab1);
        chk("t3_abandoned", 32'(ab1), 32'd1);

        // Reset in the middle of a data access, then a late mem_ready
        resp_en = 1'b0;
        @(posedge clk);
        #1;
        bus.dmem_en = 1'b1; bus.dmem_addr = 32'h400;
        bus.dmem_wdata = 32'h1234_5678; bus.dmem_rw = MEM_RW_HALF;
        @(negedge clk);
        @(negedge clk);
        chk("t4_serving_en", 32'(bus.mem_en), 32'd1);
        chk("t4_serving_wdata", bus.mem_wdata, 32'h1234_5678);
        @(posedge clk);
        #1 rst = 1'b1; bus.dmem_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_mem_en", 32'(bus.mem_en), 32'd0);
        chk("t4_mem_addr", bus.mem_addr, 32'd0);
        chk("t4_mem_wdata", bus.mem_wdata, 32'd0);
        chk("t4_mem_rw", 32'(bus.mem_rw), 32'd0);
        resp_en = 1'b1;
        inject_req++;
        @(negedge clk);
        chk("t4_late_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("t4_no_dmem_ready", 32'(bus.dmem_ready), 32'd0);
        @(negedge clk);
        chk("t4_still_idle", 32'(bus.mem_en), 32'd0);

        // Stray mem_ready while idle
        inject_req++;
        @(negedge clk);
        chk("t6_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("t6_no_readies", 32'({bus.imem_ready, bus.dmem_ready}), 32'd0);
        @(negedge clk);
        chk("t6_mem_en", 32'(bus.mem_en), 32'd0);
        lat_cfg = 0;
        do_req(1'b0, 32'h600, 32'h0, MEM_RW_READ, -1, n1, ab1);
        chk("t6_idle_latency", n1, 32'd2);

        // Memory never answers
        resp_en = 1'b0;
`ifdef ELBETH_MEM_TIMEOUT_EN
        e.addr = 32'h500; e.wdata = 32'h0; e.rw = MEM_RW_READ; e.data = 32'h0; e.err = 1'b1;
        dq.push_back(e);
        @(posedge clk);
        #1;
        bus.dmem_en = 1'b1; bus.dmem_addr = 32'h500; bus.dmem_wdata = 32'h0; bus.dmem_rw = MEM_RW_READ;
        n1 = 0;
        cnt = 0;
        while (cnt == 0 && n1 < 20) begin
            @(negedge clk);
            n1++;
            if (bus.dmem_ready) cnt = 1;
        end
        chk("t5_timeout_cycle", n1, 32'd6);
        @(posedge clk);
        #1 bus.dmem_en = 1'b0;
        @(negedge clk);
        chk("t5_mem_en_dropped", 32'(bus.mem_en), 32'd0);
`else
        @(posedge clk);
        #1;
        bus.dmem_en = 1'b1; bus.dmem_addr = 32'h500; bus.dmem_wdata = 32'h0; bus.dmem_rw = MEM_RW_READ;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.dmem_ready) cnt++;
        end
        chk("t5_no_ready", cnt, 32'd0);
        chk("t5_mem_en_held", 32'(bus.mem_en), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1; bus.dmem_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_cleanup", 32'(bus.mem_en), 32'd0);
`endif
        resp_en = 1'b1;

        // Random traffic from both ports with random memory latency
        lat_cfg = -1;
        fork
            rand_port(1'b0);
            rand_port(1'b1);
        join
        repeat (5) @(negedge clk);
        chk("drain_imem", iq.size(), 32'd0);
        chk("drain_dmem", dq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
